// File: rtl/fetch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_hazard_ctrl
//   IF-stage sequencer for the 5-stage MIPS pipeline. Holds fetch through a
//   post-reset boot window, inserts one-cycle load-use stalls, squashes the
//   wrong-path fetch on a taken branch (PCSrc) and freezes fetch on halt_req.
//   Control outputs are a zero-latency combinational decode of state and
//   inputs.
//
//   Optional feature macro: FETCH_PERF_CNT_EN
//     defined     -> saturating stall_cnt / flush_cnt counters are built
//     not defined -> no counter registers, stall_cnt / flush_cnt read 0
// ---------------------------------------------------------------------------
module fetch_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrc,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Boot counter is wide enough to hold BOOT_CYCLES itself.
  localparam int BOOT_W = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES);
  localparam logic [BOOT_W-1:0] BOOT_ONE  = BOOT_W'(1);
  localparam logic [BOOT_W-1:0] BOOT_ZERO = BOOT_W'(0);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // With an empty boot window the first cycle after reset release must
  // already be RUN, so reset lands directly in RUN in that configuration.
  localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

  state_t            state_r;
  state_t            next_state_s;
  logic [BOOT_W-1:0] boot_ctr_r;
  logic              hazard_s;
  logic              pc_write_s;
  logic              if_id_write_s;
  logic              if_id_flush_s;
  logic              id_ex_flush_s;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    hazard_s = ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
               ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
  end

  // State register; reset from any state reruns the whole boot window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Boot window countdown, only running while in BOOT.
  always_ff @(posedge clk) begin
    if (reset) begin
      boot_ctr_r <= BOOT_INIT;
    end else if ((state_r == ST_BOOT) && (boot_ctr_r != BOOT_ZERO)) begin
      boot_ctr_r <= boot_ctr_r - BOOT_ONE;
    end else begin
      boot_ctr_r <= boot_ctr_r;
    end
  end

  // Next-state and control decode; RUN priority is PCSrc > hazard > halt_req.
  always_comb begin
    next_state_s  = state_r;
    pc_write_s    = 1'b0;
    if_id_write_s = 1'b0;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    if (reset) begin
      next_state_s = RESET_STATE;
    end else begin
      case (state_r)
        ST_BOOT: begin
          // The cycle holding count 1 is the last boot cycle.
          if (boot_ctr_r <= BOOT_ONE) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_BOOT;
          end
        end
        ST_RUN: begin
          if (PCSrc) begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            if (halt_req) begin
              next_state_s = ST_HALT;
            end else begin
              next_state_s = ST_RUN;
            end
          end else if (hazard_s) begin
            id_ex_flush_s = 1'b1;
            next_state_s  = ST_STALL;
          end else if (halt_req) begin
            next_state_s = ST_HALT;
          end else begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
            next_state_s  = ST_RUN;
          end
        end
        ST_STALL: begin
          // Single stall cycle; a halt request waits until RUN.
          pc_write_s    = 1'b1;
          if_id_write_s = 1'b1;
          if (PCSrc) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else begin
            if_id_flush_s = 1'b0;
            id_ex_flush_s = 1'b0;
          end
          next_state_s = ST_RUN;
        end
        ST_HALT: begin
          // Frozen upstream, so a branch here is ignored.
          if (halt_req) begin
            next_state_s = ST_HALT;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        default: begin
          next_state_s = RESET_STATE;
        end
      endcase
    end
  end

  assign pc_write    = pc_write_s;
  assign if_id_write = if_id_write_s;
  assign if_id_flush = if_id_flush_s;
  assign id_ex_flush = id_ex_flush_s;
  assign state_o     = state_r;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             stall_inc_s;
  logic             flush_inc_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (&val) begin
      sat_inc = val;
    end else begin
      sat_inc = val + CNT_ONE;
    end
  endfunction

  // Count events: a stall cycle taken, or a taken-branch flush in RUN/STALL.
  always_comb begin
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    if (reset) begin
      stall_inc_s = 1'b0;
      flush_inc_s = 1'b0;
    end else begin
      stall_inc_s = (state_r == ST_STALL) && !PCSrc;
      flush_inc_s = PCSrc && ((state_r == ST_RUN) || (state_r == ST_STALL));
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_hazard_ctrl
//   Scoreboard bench: the driver applies one input vector per cycle, asks a
//   behavioural model for the expected outputs and queues them; a monitor on
//   the falling edge pops and compares. Directed scenarios first, then
//   randomized traffic.
// ---------------------------------------------------------------------------
module tb_fetch_hazard_ctrl;

  localparam int BOOT = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Model phase codes, matching the state_o encoding.
  localparam int P_BOOT  = 0;
  localparam int P_RUN   = 1;
  localparam int P_STALL = 2;
  localparam int P_HALT  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          PCSrc = 1'b0;
  logic          ID_EX_MemRead = 1'b0;
  logic [4:0]    ID_EX_rt = 5'd0;
  logic [4:0]    IF_ID_rs = 5'd0;
  logic [4:0]    IF_ID_rt = 5'd0;
  logic          halt_req = 1'b0;
  logic          pc_write;
  logic          if_id_write;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_rt(ID_EX_rt), .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .halt_req(halt_req), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [3:0] ctl;   // {pc_write, if_id_write, if_id_flush, id_ex_flush}
    int         st;    // -1 while the model state is not yet known
    int         scnt;
    int         fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state.
  int m_phase   = P_BOOT;
  int m_boot    = 0;
  int m_stalls  = 0;
  int m_flushes = 0;
  bit m_known   = 1'b0;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic cmp(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Apply one cycle of stimulus, queue its expected outputs, advance the model.
  task automatic step(input bit r, input bit p, input bit mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input bit h);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    reset = r; PCSrc = p; ID_EX_MemRead = mr;
    ID_EX_rt = ert; IF_ID_rs = rs; IF_ID_rt = rt; halt_req = h;

    hz     = mr && (ert != 5'd0) && ((ert == rs) || (ert == rt));
    e.st   = m_known ? m_phase : -1;
    e.scnt = PERF ? m_stalls : 0;
    e.fcnt = PERF ? m_flushes : 0;
    if (r || !m_known) begin
      e.ctl = 4'b0000;
    end else if (m_phase == P_RUN) begin
      if (p)       e.ctl = 4'b1111;
      else if (hz) e.ctl = 4'b0001;
      else if (h)  e.ctl = 4'b0000;
      else         e.ctl = 4'b1100;
    end else if (m_phase == P_STALL) begin
      e.ctl = p ? 4'b1111 : 4'b1100;
    end else begin
      e.ctl = 4'b0000;
    end
    sb_q.push_back(e);

    if (r) begin
      m_known   = 1'b1;
      m_boot    = BOOT;
      m_phase   = (BOOT == 0) ? P_RUN : P_BOOT;
      m_stalls  = 0;
      m_flushes = 0;
    end else if (m_known) begin
      if (m_phase == P_BOOT) begin
        m_boot = m_boot - 1;
        if (m_boot <= 0) m_phase = P_RUN;
      end else if (m_phase == P_RUN) begin
        if (p) begin
          m_flushes = sat(m_flushes);
          m_phase   = h ? P_HALT : P_RUN;
        end else if (hz) begin
          m_phase = P_STALL;
        end else if (h) begin
          m_phase = P_HALT;
        end
      end else if (m_phase == P_STALL) begin
        if (p) m_flushes = sat(m_flushes);
        else   m_stalls  = sat(m_stalls);
        m_phase = P_RUN;
      end else begin
        m_phase = h ? P_HALT : P_RUN;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      cmp("ctl", int'({pc_write, if_id_write, if_id_flush, id_ex_flush}), int'(mon_e.ctl));
      if (mon_e.st >= 0) begin
        cmp("state_o", int'(state_o), mon_e.st);
        cmp("stall_cnt", int'(stall_cnt), mon_e.scnt);
        cmp("flush_cnt", int'(flush_cnt), mon_e.fcnt);
      end
    end
  end

  bit rh;
  initial begin
    // Reset for two cycles, then the boot window into RUN.
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(7);
    // Load-use stall then the STALL cycle.
    step(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    idle(3);
    // Load to $zero never stalls.
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    // Branch together with a hazard: flush wins, no stall.
    step(1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    idle(2);
    // Halt for three cycles, release, then reset while halted.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(3);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle(7);
    // Five flushes against a 2-bit counter.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    // Randomized traffic with a sticky halt request and rare resets.
    rh = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rh = ~rh;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), rh);
    end
    idle(1);
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
